// File: rtl/dwt97_line_sequencer.sv
// -----------------------------------------------------------------------------
// dwt97_line_sequencer
//
// Frames a raw stream of {odd, even} sample pairs into lines and frames for a
// DWT 9/7 1D lifting processing unit.
// - After each line it appends FlushBeats zero pair-beats so the unit's delay
//   buffers drain.
// - On the return path it discards the first FlushBeats (warm-up) outputs of
//   every line and re-frames the remaining coefficients for the downstream
//   stage.
//
// Ports
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   cfg_pairs_i, cfg_lines_i         pairs per line / lines per frame (latched on start)
//   start_i, busy_o, done_o, err_o   frame control and sticky framing error
//   s_*                              raw pair input stream {odd, even}
//   pu_*                             stream towards the processing unit
//   pr_*                             stream returning from the processing unit
//   m_*                              framed coefficient output {high, low}
// -----------------------------------------------------------------------------
module dwt97_line_sequencer #(
    parameter int DataWidth       = 16,
    parameter int MaximumSideSize = 512,
    parameter int FlushBeats      = 2,
    localparam int CntWidth       = $clog2(MaximumSideSize) + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [CntWidth-1:0]    cfg_pairs_i,
    input  logic [CntWidth-1:0]    cfg_lines_i,
    input  logic                   start_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic                   s_ready_o,
    input  logic                   s_valid_i,
    input  logic [2*DataWidth-1:0] s_data_i,
    input  logic                   pu_ready_i,
    output logic                   pu_valid_o,
    output logic                   pu_sof_o,
    output logic                   pu_eol_o,
    output logic [2*DataWidth-1:0] pu_data_o,
    output logic                   pr_ready_o,
    input  logic                   pr_valid_i,
    input  logic                   pr_sof_i,
    input  logic                   pr_eol_i,
    input  logic [2*DataWidth-1:0] pr_data_i,
    input  logic                   m_ready_i,
    output logic                   m_valid_o,
    output logic                   m_sof_o,
    output logic                   m_eol_o,
    output logic [2*DataWidth-1:0] m_data_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LINE,
        ST_FLUSH,
        ST_DRAIN
    } state_e;

    localparam logic [CntWidth-1:0] CntOne       = CntWidth'(1);
    localparam logic [CntWidth-1:0] FlushCnt     = CntWidth'(FlushBeats);
    localparam logic [CntWidth-1:0] FlushLastOff = CntWidth'(FlushBeats - 1);
    localparam logic [2:0]          FlushLast    = 3'(FlushBeats - 1);

    state_e              state_q, state_d;
    logic [CntWidth-1:0] cfg_pairs_q, cfg_lines_q;
    logic [CntWidth-1:0] pair_cnt_q, line_idx_q;
    logic [2:0]          flush_cnt_q;
    logic [CntWidth-1:0] out_beat_q, out_line_q;
    logic                busy_q, done_q, err_q;

    logic start_acc;
    logic pu_xfer, pr_xfer;
    logic in_last_pair, in_last_line, flush_last;
    logic out_last_beat, out_last_line, out_first_beat;
    logic frame_end;

    assign start_acc      = start_i & ~busy_q;
    assign pu_xfer        = pu_valid_o & pu_ready_i;
    assign pr_xfer        = pr_valid_i & pr_ready_o;
    assign in_last_pair   = (pair_cnt_q == cfg_pairs_q - CntOne);
    assign in_last_line   = (line_idx_q == cfg_lines_q - CntOne);
    assign flush_last     = (flush_cnt_q == FlushLast);
    // A returned line is cfg_pairs + FlushBeats beats long: warm-up beats first.
    assign out_last_beat  = (out_beat_q == cfg_pairs_q + FlushLastOff);
    assign out_last_line  = (out_line_q == cfg_lines_q - CntOne);
    assign out_first_beat = (out_line_q == '0) && (out_beat_q == '0);
    // The final returned beat is always a forwarded one, so pr_xfer implies
    // the downstream accepted it.
    assign frame_end      = busy_q & pr_xfer & out_last_beat & out_last_line;

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign err_o  = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Input-side next state and stream muxing.
    always_comb begin
        state_d    = state_q;
        s_ready_o  = 1'b0;
        pu_valid_o = 1'b0;
        pu_sof_o   = 1'b0;
        pu_eol_o   = 1'b0;
        pu_data_o  = '0;
        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    state_d = ST_LINE;
                end
            end
            ST_LINE: begin
                pu_valid_o = s_valid_i;
                s_ready_o  = pu_ready_i;
                pu_data_o  = s_data_i;
                pu_sof_o   = s_valid_i & (line_idx_q == '0) & (pair_cnt_q == '0);
                if (s_valid_i && pu_ready_i && in_last_pair) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                pu_valid_o = 1'b1;
                pu_eol_o   = flush_last;
                if (pu_ready_i && flush_last) begin
                    state_d = in_last_line ? ST_DRAIN : ST_LINE;
                end
            end
            ST_DRAIN: begin
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Frame completion is decided by the output side, whatever the input
        // side is doing at that moment.
        if (frame_end) begin
            state_d = ST_IDLE;
        end
    end

    // Output side: drop warm-up beats, forward the rest with fresh markers.
    always_comb begin
        pr_ready_o = 1'b0;
        m_valid_o  = 1'b0;
        m_sof_o    = 1'b0;
        m_eol_o    = 1'b0;
        m_data_o   = '0;
        if (busy_q) begin
            if (out_beat_q < FlushCnt) begin
                pr_ready_o = 1'b1;
            end else begin
                m_valid_o  = pr_valid_i;
                pr_ready_o = m_ready_i;
                m_data_o   = pr_data_i;
                m_sof_o    = pr_valid_i & (out_line_q == '0) & (out_beat_q == FlushCnt);
                m_eol_o    = pr_valid_i & out_last_beat;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_pairs_q <= '0;
            cfg_lines_q <= '0;
            pair_cnt_q  <= '0;
            line_idx_q  <= '0;
            flush_cnt_q <= '0;
            out_beat_q  <= '0;
            out_line_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= frame_end;
            if (start_acc) begin
                cfg_pairs_q <= cfg_pairs_i;
                cfg_lines_q <= cfg_lines_i;
                pair_cnt_q  <= '0;
                line_idx_q  <= '0;
                flush_cnt_q <= '0;
                out_beat_q  <= '0;
                out_line_q  <= '0;
                busy_q      <= 1'b1;
                err_q       <= 1'b0;
            end else begin
                if (pu_xfer) begin
                    if (state_q == ST_LINE) begin
                        pair_cnt_q <= in_last_pair ? '0 : pair_cnt_q + CntOne;
                    end else if (state_q == ST_FLUSH) begin
                        if (flush_last) begin
                            flush_cnt_q <= '0;
                            if (!in_last_line) begin
                                line_idx_q <= line_idx_q + CntOne;
                            end
                        end else begin
                            flush_cnt_q <= flush_cnt_q + 3'd1;
                        end
                    end
                end
                // Markers from the unit are only checked; framing always
                // follows the local counters.
                if (pr_xfer) begin
                    if (out_last_beat) begin
                        out_beat_q <= '0;
                        out_line_q <= out_line_q + CntOne;
                    end else begin
                        out_beat_q <= out_beat_q + CntOne;
                    end
                    if ((pr_eol_i != out_last_beat) || (pr_sof_i != out_first_beat)) begin
                        err_q <= 1'b1;
                    end
                end
                if (frame_end) begin
                    busy_q      <= 1'b0;
                    pair_cnt_q  <= '0;
                    line_idx_q  <= '0;
                    flush_cnt_q <= '0;
                    out_beat_q  <= '0;
                    out_line_q  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dwt97_line_sequencer.sv
module tb_dwt97_line_sequencer;

    localparam int DW = 16;
    localparam int FB = 2;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic [9:0]    cfg_pairs_i, cfg_lines_i;
    logic          start_i;
    logic          busy_o, done_o, err_o;
    logic          s_ready_o, s_valid_i;
    logic [31:0]   s_data_i;
    logic          pu_ready_i, pu_valid_o, pu_sof_o, pu_eol_o;
    logic [31:0]   pu_data_o;
    logic          pr_ready_o, pr_valid_i, pr_sof_i, pr_eol_i;
    logic [31:0]   pr_data_i;
    logic          m_ready_i, m_valid_o, m_sof_o, m_eol_o;
    logic [31:0]   m_data_o;

    int checks = 0;
    int errors = 0;

    dwt97_line_sequencer #(.DataWidth(DW), .MaximumSideSize(512), .FlushBeats(FB)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .cfg_pairs_i(cfg_pairs_i), .cfg_lines_i(cfg_lines_i),
        .start_i(start_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .s_ready_o(s_ready_o), .s_valid_i(s_valid_i), .s_data_i(s_data_i),
        .pu_ready_i(pu_ready_i), .pu_valid_o(pu_valid_o), .pu_sof_o(pu_sof_o),
        .pu_eol_o(pu_eol_o), .pu_data_o(pu_data_o),
        .pr_ready_o(pr_ready_o), .pr_valid_i(pr_valid_i), .pr_sof_i(pr_sof_i),
        .pr_eol_i(pr_eol_i), .pr_data_i(pr_data_i),
        .m_ready_i(m_ready_i), .m_valid_o(m_valid_o), .m_sof_o(m_sof_o),
        .m_eol_o(m_eol_o), .m_data_o(m_data_o)
    );

    always #5 clk = ~clk;

    // Source pair i: low half is i, high half is i scrambled.
    function automatic logic [31:0] ramp(input int i);
        logic [15:0] lo;
        lo = i[15:0];
        return {lo ^ 16'hA5A5, lo};
    endfunction

    // Expected beat i at the unit input: {sof, eol, data}.
    function automatic logic [33:0] exp_pu(input int i, input int pairs);
        int len, ln, j;
        logic [31:0] d;
        len = pairs + FB;
        ln  = i / len;
        j   = i % len;
        d   = (j < pairs) ? ramp(ln * pairs + j) : 32'h0;
        return {(i == 0), (j == len - 1), d};
    endfunction

    // Expected downstream beat k: {sof, eol, data}.
    function automatic logic [33:0] exp_m(input int k, input int pairs);
        return {(k == 0), ((k % pairs) == pairs - 1), ramp(k)};
    endfunction

    // Control shared with the environment process.
    bit clr_req = 0, src_en = 0, inj_en = 0;
    int ppu = 100, pm = 100, ppr = 100;

    // Environment state (written only by the environment process).
    logic [34:0] pr_q[$];
    logic [33:0] pu_log[$], m_log[$];
    logic [31:0] hist[0:511];
    logic [33:0] m_prev, pu_prev;
    int  pj, pline, cyc, src_idx;
    int  done_cnt, done_cyc, last_m_cyc, inj_cyc, err_rise_cyc, stall_viol, busy_overlap;
    bit  s_x, pr_x, pr_pres, m_stall_prev, pu_stall_prev;

    // Environment: source, model processing unit (FlushBeats beats of delay
    // with junk warm-up outputs, markers aligned to its input), sink and logger.
    initial begin
        logic [31:0] d;
        logic        injb;
        s_valid_i = 0; s_data_i = '0; pu_ready_i = 0; m_ready_i = 0;
        pr_valid_i = 0; pr_sof_i = 0; pr_eol_i = 0; pr_data_i = '0;
        pj = 0; pline = 0; cyc = 0; src_idx = 0; pr_pres = 0; s_x = 0; pr_x = 0;
        done_cnt = 0; done_cyc = -1; last_m_cyc = -1; inj_cyc = -1; err_rise_cyc = -1;
        stall_viol = 0; busy_overlap = 0; m_stall_prev = 0; pu_stall_prev = 0;
        m_prev = '0; pu_prev = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (clr_req) begin
                pu_log.delete(); m_log.delete(); pr_q.delete();
                pj = 0; pline = 0; done_cnt = 0; done_cyc = -1; last_m_cyc = -1;
                inj_cyc = -1; err_rise_cyc = -1; stall_viol = 0; busy_overlap = 0;
                s_x = 0; pr_x = 0; m_stall_prev = 0; pu_stall_prev = 0;
            end else begin
                s_x  = s_valid_i & s_ready_o;
                pr_x = pr_valid_i & pr_ready_o;
                if (pr_x && pr_pres && pr_q.size() > 0 && pr_q[0][34]) inj_cyc = cyc;
                if (pu_valid_o & pu_ready_i) begin
                    pu_log.push_back({pu_sof_o, pu_eol_o, pu_data_o});
                    if (pj < 512) hist[pj] = pu_data_o;
                    if (pj >= FB && pj - FB < 512) d = hist[pj - FB];
                    else d = 32'hDEAD_BEEF;
                    injb = inj_en && (pline == 0) && (pj == 2);
                    pr_q.push_back({injb, pu_sof_o, pu_eol_o | injb, d});
                    if (pu_eol_o) begin pj = 0; pline++; end
                    else pj++;
                end
                if (m_valid_o & m_ready_i) begin
                    m_log.push_back({m_sof_o, m_eol_o, m_data_o});
                    last_m_cyc = cyc;
                end
                if (m_stall_prev && (m_valid_o !== 1'b1 || {m_sof_o, m_eol_o, m_data_o} !== m_prev))
                    stall_viol++;
                m_stall_prev = m_valid_o & ~m_ready_i;
                m_prev = {m_sof_o, m_eol_o, m_data_o};
                if (pu_stall_prev && (pu_valid_o !== 1'b1 || {pu_sof_o, pu_eol_o, pu_data_o} !== pu_prev))
                    stall_viol++;
                pu_stall_prev = pu_valid_o & ~pu_ready_i;
                pu_prev = {pu_sof_o, pu_eol_o, pu_data_o};
                if (done_o === 1'b1) begin
                    done_cnt++;
                    done_cyc = cyc;
                    if (busy_o === 1'b1) busy_overlap++;
                end
                if (err_o === 1'b1 && err_rise_cyc < 0) err_rise_cyc = cyc;
            end
            @(posedge clk);
            #1;
            if (clr_req) begin
                src_idx = 0;
                pr_pres = 0;
            end else begin
                if (s_x) src_idx++;
                if (pr_x && pr_pres && pr_q.size() > 0) begin
                    pr_q.delete(0);
                    pr_pres = 0;
                end
            end
            if (pr_q.size() == 0) pr_pres = 0;
            if (!pr_pres && pr_q.size() > 0 && int'($urandom_range(99)) < ppr) pr_pres = 1;
            pr_valid_i = pr_pres;
            {pr_sof_i, pr_eol_i, pr_data_i} = pr_pres ? pr_q[0][33:0] : 34'h0;
            s_valid_i  = src_en;
            s_data_i   = ramp(src_idx);
            pu_ready_i = (int'($urandom_range(99)) < ppu);
            m_ready_i  = (int'($urandom_range(99)) < pm);
        end
    end

    task automatic clear_env();
        @(negedge clk); #1;
        clr_req = 1; src_en = 0;
        repeat (2) @(negedge clk);
        #1;
        clr_req = 0;
    endtask

    task automatic run_frame(input int pairs, input int lines, input int pu_p, input int m_p,
                             input int pr_p, input bit inj, input bit mid,
                             output bit ok, output bit busy1, output bit err1);
        inj_en = inj; ppu = pu_p; pm = m_p; ppr = pr_p;
        clear_env();
        src_en = 1;
        @(posedge clk); #2;
        cfg_pairs_i = 10'(pairs); cfg_lines_i = 10'(lines); start_i = 1;
        @(posedge clk); #2;
        start_i = 0;
        @(negedge clk); #1;
        busy1 = busy_o;
        err1  = err_o;
        ok = 0;
        for (int c = 0; c < 20000 && !ok; c++) begin
            @(negedge clk); #1;
            if (mid && c == 6) begin
                cfg_pairs_i = 10'd7; cfg_lines_i = 10'd5; start_i = 1;
            end
            if (mid && c == 7) start_i = 0;
            if (done_cnt > 0) ok = 1;
        end
        repeat (10) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({busy_o, done_o, err_o, s_ready_o, pu_valid_o, pu_sof_o, pu_eol_o, pr_ready_o,
             m_valid_o, m_sof_o, m_eol_o} !== 11'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0", {busy_o, done_o, err_o, s_ready_o,
                     pu_valid_o, pu_sof_o, pu_eol_o, pr_ready_o, m_valid_o, m_sof_o, m_eol_o});
        end
        checks++;
        if ({pu_data_o, m_data_o} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: pu=%h m=%h required 0", pu_data_o, m_data_o);
        end
        @(posedge clk); #2;
        rst_ni = 1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy_o, s_ready_o, pu_valid_o, pr_ready_o, m_valid_o} !== 5'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b required 0",
                     {busy_o, s_ready_o, pu_valid_o, pr_ready_o, m_valid_o});
        end
    endtask

    task automatic test_basic();
        bit ok, b1, e1;
        run_frame(4, 2, 100, 100, 100, 0, 0, ok, b1, e1);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_done_timeout: got %0d required 1", ok); end
        checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL basic_busy_after_start: got %0d required 1", b1); end
        checks++; if (pu_log.size() != 12) begin errors++; $display("FAIL basic_pu_count: got %0d required 12", pu_log.size()); end
        checks++; if (pu_log[0] !== {2'b10, ramp(0)}) begin errors++; $display("FAIL basic_pu0: got %h required %h", pu_log[0], {2'b10, ramp(0)}); end
        checks++; if (pu_log[3] !== {2'b00, ramp(3)}) begin errors++; $display("FAIL basic_pu3: got %h required %h", pu_log[3], {2'b00, ramp(3)}); end
        checks++; if (pu_log[4] !== 34'h0) begin errors++; $display("FAIL basic_pu4_flush: got %h required 0", pu_log[4]); end
        checks++; if (pu_log[5] !== {2'b01, 32'h0}) begin errors++; $display("FAIL basic_pu5_eol: got %h required %h", pu_log[5], {2'b01, 32'h0}); end
        checks++; if (pu_log[6] !== {2'b00, ramp(4)}) begin errors++; $display("FAIL basic_pu6: got %h required %h", pu_log[6], {2'b00, ramp(4)}); end
        checks++; if (pu_log[11] !== {2'b01, 32'h0}) begin errors++; $display("FAIL basic_pu11_eol: got %h required %h", pu_log[11], {2'b01, 32'h0}); end
        checks++; if (m_log.size() != 8) begin errors++; $display("FAIL basic_m_count: got %0d required 8", m_log.size()); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (m_log[k] !== exp_m(k, 4)) begin
                errors++;
                $display("FAIL basic_m%0d: got %h required %h", k, m_log[k], exp_m(k, 4));
            end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_pulses: got %0d required 1", done_cnt); end
        checks++; if (done_cyc != last_m_cyc + 1) begin errors++; $display("FAIL basic_done_latency: done at %0d required %0d", done_cyc, last_m_cyc + 1); end
        checks++; if (busy_overlap != 0) begin errors++; $display("FAIL basic_busy_with_done: got %0d required 0", busy_overlap); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL basic_err: got %0d required 0", err_o); end
    endtask

    task automatic test_backpressure();
        bit ok, b1, e1;
        int bad, first;
        run_frame(256, 3, 50, 50, 60, 0, 0, ok, b1, e1);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_done_timeout: got %0d required 1", ok); end
        checks++; if (pu_log.size() != 258 * 3) begin errors++; $display("FAIL bp_pu_count: got %0d required %0d", pu_log.size(), 258 * 3); end
        bad = 0; first = -1;
        for (int i = 0; i < pu_log.size(); i++)
            if (pu_log[i] !== exp_pu(i, 256)) begin bad++; if (first < 0) first = i; end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_pu_beats: %0d wrong beats (first %0d) required 0", bad, first); end
        checks++; if (m_log.size() != 768) begin errors++; $display("FAIL bp_m_count: got %0d required 768", m_log.size()); end
        bad = 0; first = -1;
        for (int k = 0; k < m_log.size(); k++)
            if (m_log[k] !== exp_m(k, 256)) begin bad++; if (first < 0) first = k; end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_m_beats: %0d wrong beats (first %0d) required 0", bad, first); end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stall_stable: got %0d changes required 0", stall_viol); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_pulses: got %0d required 1", done_cnt); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL bp_err: got %0d required 0", err_o); end
    endtask

    task automatic test_min_frame();
        bit ok, b1, e1;
        run_frame(1, 1, 100, 100, 100, 0, 0, ok, b1, e1);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL min_done_timeout: got %0d required 1", ok); end
        checks++; if (pu_log.size() != 3) begin errors++; $display("FAIL min_pu_count: got %0d required 3", pu_log.size()); end
        checks++; if (pu_log[0] !== {2'b10, ramp(0)}) begin errors++; $display("FAIL min_pu0: got %h required %h", pu_log[0], {2'b10, ramp(0)}); end
        checks++; if (pu_log[1] !== 34'h0) begin errors++; $display("FAIL min_pu1: got %h required 0", pu_log[1]); end
        checks++; if (pu_log[2] !== {2'b01, 32'h0}) begin errors++; $display("FAIL min_pu2: got %h required %h", pu_log[2], {2'b01, 32'h0}); end
        checks++; if (m_log.size() != 1) begin errors++; $display("FAIL min_m_count: got %0d required 1", m_log.size()); end
        checks++; if (m_log[0] !== {2'b11, ramp(0)}) begin errors++; $display("FAIL min_m0: got %h required %h", m_log[0], {2'b11, ramp(0)}); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL min_done_pulses: got %0d required 1", done_cnt); end
        checks++; if (done_cyc != last_m_cyc + 1) begin errors++; $display("FAIL min_done_latency: done at %0d required %0d", done_cyc, last_m_cyc + 1); end
    endtask

    task automatic test_busy_start();
        bit ok, b1, e1;
        int bad;
        run_frame(4, 2, 100, 70, 100, 0, 1, ok, b1, e1);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL busystart_done_timeout: got %0d required 1", ok); end
        checks++; if (pu_log.size() != 12) begin errors++; $display("FAIL busystart_pu_count: got %0d required 12", pu_log.size()); end
        checks++; if (m_log.size() != 8) begin errors++; $display("FAIL busystart_m_count: got %0d required 8", m_log.size()); end
        bad = 0;
        for (int k = 0; k < m_log.size(); k++) if (m_log[k] !== exp_m(k, 4)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL busystart_m_beats: %0d wrong required 0", bad); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL busystart_done_pulses: got %0d required 1", done_cnt); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL busystart_idle_after: got %0d required 0", busy_o); end
        start_i = 0;
    endtask

    task automatic test_early_eol();
        bit ok, b1, e1;
        int bad;
        run_frame(4, 2, 100, 100, 100, 1, 0, ok, b1, e1);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL eol_done_timeout: got %0d required 1", ok); end
        checks++; if (inj_cyc < 0 || err_rise_cyc != inj_cyc + 1) begin errors++; $display("FAIL eol_err_timing: rose at %0d required %0d", err_rise_cyc, inj_cyc + 1); end
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL eol_err_sticky: got %0d required 1", err_o); end
        checks++; if (m_log.size() != 8) begin errors++; $display("FAIL eol_m_count: got %0d required 8", m_log.size()); end
        bad = 0;
        for (int k = 0; k < m_log.size(); k++) if (m_log[k] !== exp_m(k, 4)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL eol_m_framing: %0d wrong required 0", bad); end
        run_frame(2, 1, 100, 100, 100, 0, 0, ok, b1, e1);
        checks++; if (e1 !== 1'b0) begin errors++; $display("FAIL eol_err_cleared_on_start: got %0d required 0", e1); end
        checks++; if (err_o !== 1'b0 || ok !== 1'b1) begin errors++; $display("FAIL eol_clean_frame: err=%0d done=%0d required 0/1", err_o, ok); end
    endtask

    task automatic test_reset_mid();
        bit ok, b1, e1;
        bit reached;
        int bad;
        ppu = 100; pm = 100; ppr = 100; inj_en = 0;
        clear_env();
        src_en = 1;
        @(posedge clk); #2;
        cfg_pairs_i = 10'd4; cfg_lines_i = 10'd3; start_i = 1;
        @(posedge clk); #2;
        start_i = 0;
        reached = 0;
        for (int c = 0; c < 200 && !reached; c++) begin
            @(negedge clk); #1;
            if (pu_log.size() >= 8) reached = 1;
        end
        checks++; if (reached !== 1'b1) begin errors++; $display("FAIL rstmid_line1_timeout: got %0d required 1", reached); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %0d required 1", busy_o); end
        #2;
        rst_ni = 0;
        #1;
        checks++;
        if ({busy_o, done_o, err_o, s_ready_o, pu_valid_o, pu_sof_o, pu_eol_o, pr_ready_o,
             m_valid_o, m_sof_o, m_eol_o, pu_data_o, m_data_o} !== 75'b0) begin
            errors++;
            $display("FAIL rstmid_outputs: ctrl=%b pu=%h m=%h required 0", {busy_o, done_o, err_o,
                     s_ready_o, pu_valid_o, pu_sof_o, pu_eol_o, pr_ready_o, m_valid_o, m_sof_o,
                     m_eol_o}, pu_data_o, m_data_o);
        end
        repeat (2) @(negedge clk);
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d required 0", done_cnt); end
        @(posedge clk); #2;
        rst_ni = 1;
        run_frame(3, 2, 100, 100, 100, 0, 0, ok, b1, e1);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_after_timeout: got %0d required 1", ok); end
        checks++; if (pu_log.size() != 10) begin errors++; $display("FAIL rstmid_pu_count: got %0d required 10", pu_log.size()); end
        checks++; if (m_log.size() != 6) begin errors++; $display("FAIL rstmid_m_count: got %0d required 6", m_log.size()); end
        bad = 0;
        for (int k = 0; k < m_log.size(); k++) if (m_log[k] !== exp_m(k, 3)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_m_beats: %0d wrong required 0", bad); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL rstmid_done_pulses: got %0d required 1", done_cnt); end
    endtask

    initial begin
        rst_ni = 0;
        start_i = 0;
        cfg_pairs_i = '0;
        cfg_lines_i = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_min_frame();
        test_busy_start();
        test_early_eol();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dwt97_line_sequencer.md
# dwt97_line_sequencer

Frame/line sequencer that drives one DWT 9/7 1D lifting processing unit. It frames a raw stream of `{odd, even}` sample pairs into lines and frames with `sof`/`eol` markers. After each line it appends zero flush beats so the unit's internal delay buffers drain. On the return path it discards the warm-up outputs of each line and re-frames the valid coefficients for the downstream stage. It sits between the sample source (or transpose buffer) and the next lifting/quantisation stage, one instance per 1D pass.

## Interface
Parameters:
- `DataWidth`, 16, width of one sample; pair buses are 2*DataWidth wide.
- `MaximumSideSize`, 512, maximum line length in samples; `CntWidth = $clog2(MaximumSideSize)+1`.
- `FlushBeats`, 2, zero pair-beats appended per line; also the number of leading outputs dropped per line. Legal range 1..7.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `cfg_pairs_i`  in  CntWidth  pairs per line, 1..MaximumSideSize/2; sampled on start.
- `cfg_lines_i`  in  CntWidth  lines per frame, 1..MaximumSideSize; sampled on start.
- `start_i`  in  1  frame start request.
- `busy_o`  out  1  frame in progress.
- `done_o`  out  1  one-cycle pulse at frame completion.
- `err_o`  out  1  sticky framing error.
- `s_ready_o` / `s_valid_i` / `s_data_i`  out / in / in  1 / 1 / 2*DataWidth  raw pair input `{odd, even}`.
- `pu_ready_i` / `pu_valid_o` / `pu_sof_o` / `pu_eol_o` / `pu_data_o`  in / out / out / out / out  1 / 1 / 1 / 1 / 2*DataWidth  stream to the processing unit.
- `pr_ready_o` / `pr_valid_i` / `pr_sof_i` / `pr_eol_i` / `pr_data_i`  out / in / in / in / in  1 / 1 / 1 / 1 / 2*DataWidth  stream from the processing unit.
- `m_ready_i` / `m_valid_o` / `m_sof_o` / `m_eol_o` / `m_data_o`  in / out / out / out / out  1 / 1 / 1 / 1 / 2*DataWidth  framed coefficient output `{high, low}`.

## Operation
- **Start.** Accept `start_i` only when `busy_o`=0.
  - Latch `cfg_pairs_i` and `cfg_lines_i`, clear `err_o`, set `busy_o`, enter LINE.
  - `start_i` while busy is ignored; config changes mid-frame have no effect.
- **Input FSM states:** IDLE, LINE, FLUSH, DRAIN.
- **LINE.**
  - `pu_valid_o`=`s_valid_i`, `s_ready_o`=`pu_ready_i`, `pu_data_o`=`s_data_i`.
  - A pair counter advances on each `pu_valid_o & pu_ready_i`.
  - After pair `cfg_pairs-1` is accepted, go to FLUSH.
- **FLUSH.**
  - `s_ready_o`=0, `pu_valid_o`=1, `pu_data_o`=0.
  - Emit exactly FlushBeats accepted beats.
  - After the last one: if line index = `cfg_lines-1`, go to DRAIN; else increment the line index and return to LINE.
- **Input markers.**
  - `pu_sof_o`=1 only on beat 0 of line 0.
  - `pu_eol_o`=1 only on the last flush beat of each line.
- **DRAIN.** Input side idle (`s_ready_o`=0, `pu_valid_o`=0) until the output side finishes the frame, then go to IDLE.
- **Output side.** Independent per-line beat counter counts `pr_valid_i & pr_ready_o`.
  - Beats 0..FlushBeats-1 of each line are dropped: `pr_ready_o`=1, `m_valid_o`=0.
  - Remaining beats pass through: `m_valid_o`=`pr_valid_i`, `pr_ready_o`=`m_ready_i`, `m_data_o`=`pr_data_i`.
  - `m_sof_o`=1 on the first forwarded beat of line 0.
  - `m_eol_o`=1 on forwarded beat `cfg_pairs-1` of each line.
- **Framing errors (`err_o`, sticky until next start).**
  - `pr_eol_i` arrives with line beat count ≠ `cfg_pairs+FlushBeats-1`.
  - Or the last beat arrives without `pr_eol_i`.
  - Either way, the output counter still follows its own count.
  - `pr_sof_i` is checked the same way against line 0, beat 0.
- **Frame end.** After the last forwarded beat of the last line is accepted, pulse `done_o` for one cycle, clear `busy_o`, input FSM returns to IDLE.

## Timing
- **Reset.** Asynchronous, immediate.
  - State IDLE; all counters 0.
  - Outputs: `busy_o`, `done_o`, `err_o`, `s_ready_o`, `pu_valid_o`, `pu_sof_o`, `pu_eol_o`, `pr_ready_o`, `m_valid_o`, `m_sof_o`, `m_eol_o` = 0; data buses 0.
  - Reset mid-frame abandons the frame with no `done_o`.
- **Latency.**
  - Input path and forwarded output path are combinational (0 cycles).
  - Start accepted at edge N: LINE active from cycle N+1.
  - `done_o` is registered: asserted the cycle after the final `m_valid_o & m_ready_i`.
  - `busy_o` falls in the same cycle that `done_o` rises.
- **Handshakes.** AXI-stream rules on all three streams.
  - `pu_valid_o` in FLUSH and `m_valid_o` never drop before the transfer completes.
  - Markers and data stay stable while stalled.
- **Widths and wrap.**
  - Counters are CntWidth wide and compared against the latched config, never wrapped.
  - Output line count wraps to 0 after `cfg_pairs+FlushBeats` beats.
- **Simultaneous events.**
  - A dropped beat and a forwarded beat never coincide.
  - The last input flush beat and the output-side line end may occur in the same cycle; each counter updates independently.

## Test plan
- **Basic frame, no stall.** `cfg_pairs`=4, `cfg_lines`=2, FlushBeats=2, ramp data, all ready.
  - Processing unit receives 6 beats per line: beats 4–5 are zero, `pu_sof_o` on line 0 beat 0, `pu_eol_o` on beat 5.
  - Model processing unit returns 6 beats per line; downstream gets 8 beats.
  - `m_sof_o` on beat 0, `m_eol_o` on beats 3 and 7, single `done_o` pulse.
- **Random backpressure.** Random `pu_ready_i`/`m_ready_i` (50%), `cfg_pairs`=256, `cfg_lines`=3.
  - No loss or duplication, order preserved.
  - Marker and data stable while stalled.
- **Minimum frame.** `cfg_pairs`=1, `cfg_lines`=1.
  - 3 processing-unit beats: `pu_sof_o` on beat 0, `pu_eol_o` on beat 2.
  - 1 downstream beat with `m_sof_o`=`m_eol_o`=1, then `done_o`.
- **Start and config changes while busy.** Pulse `start_i` with new config mid-frame.
  - Ignored: frame completes with the original counts, exactly one `done_o`.
- **Early `pr_eol_i`.** Inject `pr_eol_i` on line beat 2 of 6.
  - `err_o` rises next cycle and stays high until the next start.
  - Downstream framing still follows counters.
- **Reset mid-frame.** Assert `rst_ni`=0 during line 1.
  - All outputs at reset values immediately.
  - A new start afterwards produces a clean, correct frame.
